// File: rtl/wb_mux_arbiter.sv
// N-master to 1-slave Wishbone arbiter: fixed-priority or round-robin grant, held
// for the whole m_cyc window, with a stalled-strobe watchdog that errors the master out.

module wb_mux_arbiter_lane #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = 4
) (
  input  logic          sel_en,
  input  logic          err_en,
  input  logic          cyc,
  input  logic          stb,
  input  logic          we,
  input  logic [SW-1:0] sel,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] dat_w,
  input  logic          s_ack,
  output logic          ack,
  output logic          err,
  output logic          mux_cyc,
  output logic          mux_stb,
  output logic          mux_we,
  output logic [SW-1:0] mux_sel,
  output logic [AW-1:0] mux_adr,
  output logic [DW-1:0] mux_dat_w
);
  // Lanes are masked to zero unless selected, so the slave bus is a plain OR.
  assign mux_cyc   = sel_en & cyc;
  assign mux_stb   = sel_en & stb;
  assign mux_we    = sel_en & we;
  assign mux_sel   = {SW{sel_en}} & sel;
  assign mux_adr   = {AW{sel_en}} & adr;
  assign mux_dat_w = {DW{sel_en}} & dat_w;
  assign ack       = sel_en & s_ack;
  assign err       = err_en;
endmodule

module wb_mux_arbiter #(
  parameter int NM      = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR      = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NM-1:0]      m_cyc,
  input  logic [NM-1:0]      m_stb,
  input  logic [NM-1:0]      m_we,
  input  logic [NM*(DW/8)-1:0] m_sel,
  input  logic [NM*AW-1:0]   m_adr,
  input  logic [NM*DW-1:0]   m_dat_w,
  output logic [NM-1:0]      m_ack,
  output logic [NM-1:0]      m_err,
  output logic [DW-1:0]      m_dat_r,
  output logic               s_cyc,
  output logic               s_stb,
  output logic               s_we,
  output logic [DW/8-1:0]    s_sel,
  output logic [AW-1:0]      s_adr,
  output logic [DW-1:0]      s_dat_w,
  input  logic               s_ack,
  input  logic [DW-1:0]      s_dat_r,
  output logic [NM-1:0]      grant
);
  localparam int SW  = DW / 8;
  localparam int PW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  logic [1:0]     state, state_nxt;
  logic [NM-1:0]  grant_nxt;
  logic [PW-1:0]  gnt_idx, gnt_idx_nxt;
  logic [PW-1:0]  rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]  arb_base;
  logic [PW-1:0]  win_idx;
  logic           win_vld;
  logic           load;
  logic           wd_expire;
  logic [WDW-1:0] wd;
  logic           busy, in_err;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NM) s = s - NM;
    return PW'(s);
  endfunction

  assign busy     = (state == BUSY);
  assign in_err   = (state == ERR);
  assign arb_base = (RR != 0) ? rr_ptr : '0;

  // Scan downward so the entry closest to arb_base is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      if (m_cyc[wrap_add(arb_base, k)]) begin
        win_vld = 1'b1;
        win_idx = wrap_add(arb_base, k);
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
      assign wd_expire = (wd == WD_LAST) & ~s_ack & s_stb;
    end else begin : g_nowd
      assign wd_expire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    gnt_idx_nxt = gnt_idx;
    rr_ptr_nxt  = rr_ptr;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = BUSY;
          load      = 1'b1;
        end
      end
      BUSY: begin
        // Release takes precedence over the watchdog: a dropped cyc is a clean end.
        if (!m_cyc[gnt_idx]) begin
          if (win_vld) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end else if (wd_expire) begin
          state_nxt = ERR;
        end
      end
      ERR: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
    if (load) begin
      grant_nxt          = '0;
      grant_nxt[win_idx] = 1'b1;
      gnt_idx_nxt        = win_idx;
      rr_ptr_nxt         = wrap_add(win_idx, 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      gnt_idx <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      gnt_idx <= gnt_idx_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       wd <= '0;
    else if ((grant_nxt != grant) || s_ack || !s_stb) wd <= '0;
    else                                           wd <= wd + 1'b1;
  end

  logic [NM-1:0]         l_cyc, l_stb, l_we;
  logic [NM-1:0][SW-1:0] l_sel;
  logic [NM-1:0][AW-1:0] l_adr;
  logic [NM-1:0][DW-1:0] l_dat;

  for (genvar i = 0; i < NM; i++) begin : g_lane
    wb_mux_arbiter_lane #(.AW(AW), .DW(DW), .SW(SW)) u_lane (
      .sel_en    (grant[i] & busy),
      .err_en    (grant[i] & in_err),
      .cyc       (m_cyc[i]),
      .stb       (m_stb[i]),
      .we        (m_we[i]),
      .sel       (m_sel[i*SW +: SW]),
      .adr       (m_adr[i*AW +: AW]),
      .dat_w     (m_dat_w[i*DW +: DW]),
      .s_ack     (s_ack),
      .ack       (m_ack[i]),
      .err       (m_err[i]),
      .mux_cyc   (l_cyc[i]),
      .mux_stb   (l_stb[i]),
      .mux_we    (l_we[i]),
      .mux_sel   (l_sel[i]),
      .mux_adr   (l_adr[i]),
      .mux_dat_w (l_dat[i])
    );
  end

  assign s_cyc   = |l_cyc;
  assign s_stb   = |l_stb;
  assign s_we    = |l_we;
  assign m_dat_r = s_dat_r;

  always_comb begin
    s_sel   = '0;
    s_adr   = '0;
    s_dat_w = '0;
    for (int i = 0; i < NM; i++) begin
      s_sel   = s_sel   | l_sel[i];
      s_adr   = s_adr   | l_adr[i];
      s_dat_w = s_dat_w | l_dat[i];
    end
  end
endmodule

// File: tb/tb_wb_mux_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter from one stimulus stream and
// checks both against a cycle-level model plus hand-computed expectations.

module tb_wb_mux_arbiter;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic clk, rst;
  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [NM*SW-1:0] m_sel;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat_w;
  logic             s_ack, ack_man;
  int               ack_src;
  logic [DW-1:0]    s_dat_r;

  logic [NM-1:0] o_ack[2], o_err[2], o_grant[2];
  logic          o_cyc[2], o_stb[2], o_we[2];
  logic [SW-1:0] o_sel[2];
  logic [AW-1:0] o_adr[2];
  logic [DW-1:0] o_datw[2], o_datr[2];

  int n_tests = 0;
  int n_fail  = 0;

  always_comb begin
    s_ack = ack_man;
    if (ack_src == 1) s_ack = o_stb[0];
    if (ack_src == 2) s_ack = o_stb[1];
  end

  for (genvar k = 0; k < 2; k++) begin : g_dut
    wb_mux_arbiter #(.NM(NM), .AW(AW), .DW(DW), .RR(k), .TIMEOUT(TO)) u_dut (
      .clk(clk), .rst(rst),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_adr(m_adr), .m_dat_w(m_dat_w),
      .m_ack(o_ack[k]), .m_err(o_err[k]), .m_dat_r(o_datr[k]),
      .s_cyc(o_cyc[k]), .s_stb(o_stb[k]), .s_we(o_we[k]), .s_sel(o_sel[k]),
      .s_adr(o_adr[k]), .s_dat_w(o_datw[k]), .s_ack(s_ack), .s_dat_r(s_dat_r),
      .grant(o_grant[k])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: instance 0 fixed priority, instance 1 round-robin. g = granted master or -1.
  int   mg[2]  = '{-1, -1};
  bit   me[2]  = '{1'b0, 1'b0};
  int   mp[2]  = '{0, 0};
  int   mwd[2] = '{0, 0};
  logic [NM-1:0] sn_cyc = '0, sn_stb = '0;
  logic          sn_ack = 1'b0;

  function automatic int pick(input int k);
    int base = (k == 1) ? mp[k] : 0;
    for (int j = 0; j < NM; j++)
      if (sn_cyc[(base + j) % NM]) return (base + j) % NM;
    return -1;
  endfunction

  task automatic mstep(input int k);
    int  g = mg[k];
    int  ng = g;
    int  w;
    bit  stb = (g >= 0) && !me[k] && sn_stb[g];
    if (me[k]) begin
      me[k] = 1'b0;
      ng = -1;
    end else if (g < 0 || !sn_cyc[g]) begin
      w = pick(k);
      ng = w;
      if (w >= 0) mp[k] = (w + 1) % NM;
    end else if (mwd[k] == TO - 1 && !sn_ack && stb) begin
      me[k] = 1'b1;
    end
    if (ng != g || sn_ack || !stb) mwd[k] = 0;
    else mwd[k] = mwd[k] + 1;
    mg[k] = ng;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mg[k] = -1; me[k] = 1'b0; mp[k] = 0; mwd[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) mstep(k);
    end
  end

  logic [NM-1:0] e_g, e_a, e_e;
  logic          e_c, e_s, e_w;
  logic [SW-1:0] e_sel;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_dat;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      e_g = '0; e_a = '0; e_e = '0; e_c = 1'b0; e_s = 1'b0; e_w = 1'b0;
      e_sel = '0; e_adr = '0; e_dat = '0;
      if (mg[k] >= 0) begin
        e_g[mg[k]] = 1'b1;
        if (me[k]) e_e[mg[k]] = 1'b1;
        else begin
          e_c   = m_cyc[mg[k]];
          e_s   = m_stb[mg[k]];
          e_w   = m_we[mg[k]];
          e_sel = m_sel[mg[k]*SW +: SW];
          e_adr = m_adr[mg[k]*AW +: AW];
          e_dat = m_dat_w[mg[k]*DW +: DW];
          if (s_ack) e_a[mg[k]] = 1'b1;
        end
      end
      chk($sformatf("model grant[%0d]", k), 64'(o_grant[k]), 64'(e_g));
      chk($sformatf("model m_ack[%0d]", k), 64'(o_ack[k]), 64'(e_a));
      chk($sformatf("model m_err[%0d]", k), 64'(o_err[k]), 64'(e_e));
      chk($sformatf("model s_cyc[%0d]", k), 64'(o_cyc[k]), 64'(e_c));
      chk($sformatf("model s_stb[%0d]", k), 64'(o_stb[k]), 64'(e_s));
      chk($sformatf("model s_we[%0d]", k), 64'(o_we[k]), 64'(e_w));
      chk($sformatf("model s_sel[%0d]", k), 64'(o_sel[k]), 64'(e_sel));
      chk($sformatf("model s_adr[%0d]", k), 64'(o_adr[k]), 64'(e_adr));
      chk($sformatf("model s_dat_w[%0d]", k), 64'(o_datw[k]), 64'(e_dat));
      chk($sformatf("model m_dat_r[%0d]", k), 64'(o_datr[k]), 64'(s_dat_r));
    end
    sn_cyc = m_cyc;
    sn_stb = m_stb;
    sn_ack = s_ack;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input logic c, input logic s, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_cyc[i] = c;
    m_stb[i] = s;
    m_we[i]  = w;
    m_sel[i*SW +: SW]   = '1;
    m_adr[i*AW +: AW]   = a;
    m_dat_w[i*DW +: DW] = d;
  endtask

  function automatic logic [AW-1:0] adr_of(input int i);
    return AW'(32'h2000_0000 + 256 * i);
  endfunction

  function automatic logic [DW-1:0] dat_of(input int i);
    return DW'(32'hA5A5_0000 + i);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  int acks;

  initial begin
    rst = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat_w = '0;
    ack_man = 1'b0; ack_src = 0; s_dat_r = 32'h1234_5678;
    repeat (3) nxt();
    mid();
    chk("reset grant fp", 64'(o_grant[0]), 64'h0);
    chk("reset grant rr", 64'(o_grant[1]), 64'h0);
    chk("reset s_cyc", 64'(o_cyc[0]), 64'h0);
    nxt(); rst = 1'b0;
    nxt();

    // single master write
    set_m(2, 1, 1, 1, 32'h3800_0010, 32'hDEAD_BEEF);
    mid(); chk("t1 stb before grant", 64'(o_stb[0]), 64'h0); nxt();
    mid();
    chk("t1 grant", 64'(o_grant[0]), 64'h4);
    chk("t1 s_stb", 64'(o_stb[0]), 64'h1);
    chk("t1 s_adr", 64'(o_adr[0]), 64'h3800_0010);
    chk("t1 s_dat_w", 64'(o_datw[0]), 64'hDEAD_BEEF);
    chk("t1 no early ack", 64'(o_ack[0]), 64'h0);
    nxt();
    ack_man = 1'b1;
    mid(); chk("t1 ack", 64'(o_ack[0]), 64'h4); chk("t1 dat_r", 64'(o_datr[0]), 64'h1234_5678); nxt();
    ack_man = 1'b0; set_m(2, 0, 0, 0, '0, '0);
    mid(); chk("t1 grant held", 64'(o_grant[0]), 64'h4); chk("t1 s_cyc drop", 64'(o_cyc[0]), 64'h0); nxt();
    mid(); chk("t1 idle fp", 64'(o_grant[0]), 64'h0); chk("t1 idle rr", 64'(o_grant[1]), 64'h0); nxt();

    // masters 1 and 3 together
    set_m(1, 1, 1, 0, adr_of(1), dat_of(1));
    set_m(3, 1, 1, 0, adr_of(3), dat_of(3));
    mid(); nxt();
    ack_man = 1'b1;
    mid();
    chk("t2 fp first", 64'(o_grant[0]), 64'h2);
    chk("t2 rr from p=3", 64'(o_grant[1]), 64'h8);
    chk("t2 fp ack", 64'(o_ack[0]), 64'h2);
    nxt();
    ack_man = 1'b0; set_m(1, 0, 0, 0, '0, '0);
    mid(); chk("t2 fp hold", 64'(o_grant[0]), 64'h2); nxt();
    ack_man = 1'b1;
    mid();
    chk("t2 fp handover", 64'(o_grant[0]), 64'h8);
    chk("t2 fp adr3", 64'(o_adr[0]), 64'(adr_of(3)));
    chk("t2 fp ack3", 64'(o_ack[0]), 64'h8);
    nxt();
    ack_man = 1'b0; set_m(3, 0, 0, 0, '0, '0);
    mid(); nxt();
    mid(); chk("t2 idle", 64'(o_grant[0]), 64'h0); nxt();

    // round-robin rotation, zero-wait slave following the rr instance
    ack_src = 2;
    for (int i = 0; i < NM; i++) set_m(i, 1, 1, 0, adr_of(i), dat_of(i));
    mid(); nxt();
    for (int j = 0; j < 6; j++) begin
      mid();
      chk($sformatf("t3 rr seq %0d", j), 64'(o_grant[1]), 64'(4'b0001 << (j % 4)));
      chk($sformatf("t3 rr ack %0d", j), 64'(o_ack[1]), 64'(4'b0001 << (j % 4)));
      nxt();
      set_m(j % 4, 0, 0, 0, adr_of(j % 4), dat_of(j % 4));
      mid(); nxt();
      set_m(j % 4, 1, 1, 0, adr_of(j % 4), dat_of(j % 4));
    end
    for (int i = 0; i < NM; i++) set_m(i, 0, 0, 0, '0, '0);
    ack_src = 0;
    nxt(); nxt();
    mid(); chk("t3 idle", 64'(o_grant[1]), 64'h0); nxt();

    // 8-beat burst from master 0 while master 1 waits
    ack_src = 1;
    set_m(0, 1, 1, 1, adr_of(0), dat_of(0));
    mid(); nxt();
    set_m(1, 1, 1, 0, adr_of(1), dat_of(1));
    acks = 0;
    for (int b = 0; b < 8; b++) begin
      mid();
      chk($sformatf("t4 fp hold %0d", b), 64'(o_grant[0]), 64'h1);
      chk($sformatf("t4 rr hold %0d", b), 64'(o_grant[1]), 64'h1);
      if (o_ack[0][0]) acks++;
      nxt();
    end
    set_m(0, 0, 0, 0, '0, '0);
    mid(); chk("t4 hold at drop", 64'(o_grant[0]), 64'h1); if (o_ack[0][0]) acks++; nxt();
    mid();
    chk("t4 fp m1", 64'(o_grant[0]), 64'h2);
    chk("t4 rr m1", 64'(o_grant[1]), 64'h2);
    chk("t4 beats", 64'(acks), 64'd8);
    nxt();
    set_m(1, 0, 0, 0, '0, '0);
    mid(); nxt();
    mid(); chk("t4 idle", 64'(o_grant[0]), 64'h0); nxt();

    // watchdog expiry on a silent slave
    ack_src = 0; ack_man = 1'b0;
    set_m(2, 1, 1, 0, adr_of(2), dat_of(2));
    mid(); nxt();
    for (int t = 1; t <= 16; t++) begin
      mid();
      if (t == 1) chk("t5 stb rise", 64'(o_stb[0]), 64'h1);
      chk($sformatf("t5 no err %0d", t), 64'(o_err[0]), 64'h0);
      nxt();
    end
    set_m(2, 0, 0, 0, '0, '0);
    mid();
    chk("t5 err fp", 64'(o_err[0]), 64'h4);
    chk("t5 err rr", 64'(o_err[1]), 64'h4);
    chk("t5 s_cyc in err", 64'(o_cyc[0]), 64'h0);
    nxt();
    mid(); chk("t5 err once", 64'(o_err[0]), 64'h0); chk("t5 idle", 64'(o_grant[0]), 64'h0); nxt();

    // ack on the expiry cycle wins
    set_m(2, 1, 1, 0, adr_of(2), dat_of(2));
    mid(); nxt();
    repeat (15) begin mid(); nxt(); end
    ack_man = 1'b1;
    mid(); chk("t5b ack at expiry", 64'(o_ack[0]), 64'h4); chk("t5b no err", 64'(o_err[0]), 64'h0); nxt();
    ack_man = 1'b0; set_m(2, 0, 0, 0, '0, '0);
    mid(); chk("t5b no late err", 64'(o_err[0]), 64'h0); chk("t5b still busy", 64'(o_grant[0]), 64'h4); nxt();
    mid(); chk("t5b idle", 64'(o_grant[0]), 64'h0); nxt();

    // async reset mid-burst
    ack_man = 1'b1;
    set_m(2, 1, 1, 1, adr_of(2), dat_of(2));
    mid(); nxt();
    mid(); chk("t6 burst granted", 64'(o_grant[1]), 64'h4); nxt();
    mid(); nxt();
    #1;
    set_m(2, 0, 0, 0, '0, '0);
    set_m(1, 1, 1, 0, adr_of(1), dat_of(1));
    set_m(3, 1, 1, 0, adr_of(3), dat_of(3));
    rst = 1'b1;
    #1;
    chk("t6 async grant fp", 64'(o_grant[0]), 64'h0);
    chk("t6 async grant rr", 64'(o_grant[1]), 64'h0);
    chk("t6 async s_cyc", 64'(o_cyc[1]), 64'h0);
    chk("t6 async m_ack", 64'(o_ack[1]), 64'h0);
    mid(); nxt();
    rst = 1'b0;
    mid(); chk("t6 idle after release", 64'(o_grant[1]), 64'h0); nxt();
    mid(); chk("t6 rr p=0", 64'(o_grant[1]), 64'h2); chk("t6 fp", 64'(o_grant[0]), 64'h2); nxt();
    ack_man = 1'b0;
    for (int i = 0; i < NM; i++) set_m(i, 0, 0, 0, '0, '0);
    nxt(); nxt();
    mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
